// File: rtl/dfr_reservoir_loop.sv
`default_nettype none
// ============================================================================
// Module      : dfr_reservoir_loop
// Description : Time-multiplexed delay loop of the hybrid DFR reservoir.
//               Each virtual node adds the masked input sample to its own
//               scaled state from the previous frame. The sum is saturated
//               into the 16-bit domain of the Mackey-Glass block and
//               presented on mg_din_o. One cycle later the nonlinearity
//               result is written back into the delay line and streamed out
//               as reservoir state.
// Revision    : 1.0 - initial release
// ============================================================================
module dfr_reservoir_loop #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int FB_SHIFT      = 1,
  parameter int IDX_W         = $clog2(VIRTUAL_NODES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic [DATA_WIDTH-1:0] mg_din_o,
  input  logic [DATA_WIDTH-1:0] mg_dout_i,
  output logic                  node_valid_o,
  output logic [IDX_W-1:0]      node_idx_o,
  output logic [DATA_WIDTH-1:0] node_data_o,
  output logic                  frame_done_o,
  output logic                  busy_o
);

  // Largest value the nonlinearity accepts on its input.
  localparam logic [DATA_WIDTH:0]   C_SAT_LIMIT = (DATA_WIDTH+1)'(17'h0_FFFF);
  localparam logic [DATA_WIDTH-1:0] C_SAT_VALUE = DATA_WIDTH'(16'hFFFF);
  localparam logic [IDX_W-1:0]      C_LAST_IDX  = IDX_W'(VIRTUAL_NODES - 1);

  typedef enum logic [0:0] {
    S_ACCEPT = 1'b0,
    S_EVAL   = 1'b1
  } state_t;

  state_t                r_state_q;
  logic [DATA_WIDTH-1:0] r_mem_q [VIRTUAL_NODES];
  logic [IDX_W-1:0]      r_idx_q;
  logic [DATA_WIDTH-1:0] r_mg_din_q;
  logic                  r_node_valid_q;
  logic [IDX_W-1:0]      r_node_idx_q;
  logic [DATA_WIDTH-1:0] r_node_data_q;
  logic                  r_frame_done_q;
  logic                  r_busy_q;

  logic [DATA_WIDTH-1:0] w_fb_d;
  logic [DATA_WIDTH:0]   w_sum_d;
  logic [DATA_WIDTH-1:0] w_mg_din_d;
  logic [IDX_W-1:0]      w_idx_d;
  logic                  w_last_d;

  // Feedback path: scaled previous-frame state of the current node plus the
  // new sample, clamped to the nonlinearity's 16-bit input range. The read
  // happens before the EVAL write, so the node sees last frame's value.
  always_comb begin
    w_fb_d     = r_mem_q[r_idx_q] >> FB_SHIFT;
    w_sum_d    = {1'b0, in_data_i} + {1'b0, w_fb_d};
    w_mg_din_d = (w_sum_d > C_SAT_LIMIT) ? C_SAT_VALUE : w_sum_d[DATA_WIDTH-1:0];
    w_last_d   = (r_idx_q == C_LAST_IDX);
    w_idx_d    = w_last_d ? '0 : r_idx_q + 1'b1;
  end

  // Accept/evaluate sequencer with delay-line write-back and output capture.
  // rst and clear share one flush path; they only differ in in_ready_o.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state_q      <= S_ACCEPT;
      r_idx_q        <= '0;
      r_mg_din_q     <= '0;
      r_node_valid_q <= 1'b0;
      r_node_idx_q   <= '0;
      r_node_data_q  <= '0;
      r_frame_done_q <= 1'b0;
      r_busy_q       <= 1'b0;
      for (int i = 0; i < VIRTUAL_NODES; i++) begin
        r_mem_q[i] <= '0;
      end
    end else begin
      r_node_valid_q <= 1'b0;
      r_frame_done_q <= 1'b0;
      case (r_state_q)
        S_ACCEPT: begin
          if (in_valid_i) begin
            r_mg_din_q <= w_mg_din_d;
            r_busy_q   <= 1'b1;
            r_state_q  <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_mem_q[r_idx_q] <= mg_dout_i;
          r_node_data_q    <= mg_dout_i;
          r_node_idx_q     <= r_idx_q;
          r_node_valid_q   <= 1'b1;
          r_frame_done_q   <= w_last_d;
          r_idx_q          <= w_idx_d;
          r_busy_q         <= 1'b0;
          r_state_q        <= S_ACCEPT;
        end
        default: begin
          r_busy_q  <= 1'b0;
          r_state_q <= S_ACCEPT;
        end
      endcase
    end
  end

  // Ready is withheld while reset is asserted so nothing is taken during it.
  assign in_ready_o   = (r_state_q == S_ACCEPT) && !rst_i;
  assign mg_din_o     = r_mg_din_q;
  assign node_valid_o = r_node_valid_q;
  assign node_idx_o   = r_node_idx_q;
  assign node_data_o  = r_node_data_q;
  assign frame_done_o = r_frame_done_q;
  assign busy_o       = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dfr_reservoir_loop.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfr_reservoir_loop
// Description : Self-checking bench for dfr_reservoir_loop with a stand-in
//               nonlinearity and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfr_reservoir_loop;

  localparam int VN = 10;
  localparam int DW = 32;
  localparam int FB = 1;
  localparam int IW = $clog2(VN);

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready;
  logic [DW-1:0] in_data, mg_din, mg_dout, node_data;
  logic          node_valid, frame_done, busy;
  logic [IW-1:0] node_idx;
  logic [31:0]   noise;

  always #5 clk = ~clk;

  dfr_reservoir_loop #(
    .VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .FB_SHIFT(FB), .IDX_W(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .mg_din_o(mg_din), .mg_dout_i(mg_dout),
    .node_valid_o(node_valid), .node_idx_o(node_idx),
    .node_data_o(node_data), .frame_done_o(frame_done), .busy_o(busy)
  );

  // Stand-in nonlinearity: 0x100 and 0x10A map to 0x14, 0xFFFF maps to 0x4E.
  // noise lets the bench exercise the upper bits of the write-back path.
  function automatic logic [31:0] mg_stub(input logic [31:0] x);
    return 32'h14 + ((x & 32'hFFFF) * 32'd58) / 32'd65535;
  endfunction

  always_comb mg_dout = mg_stub(mg_din) ^ noise;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: one word per virtual node plus the node pointer.
  logic [31:0] m_mem [VN];
  int          m_idx;
  logic [31:0] m_last_mg;
  logic [31:0] m_last_node;

  task automatic model_reset();
    for (int i = 0; i < VN; i++) m_mem[i] = 32'h0;
    m_idx = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full node: accept, check mg_din during EVAL, check the output pulse.
  // in_valid is left high so back-to-back calls model a continuous producer.
  task automatic do_node(input logic [31:0] data, input bit use_tab,
                         input logic [31:0] t_mg, input logic [31:0] t_node,
                         input int t_idx, input bit t_fd);
    logic [32:0] sum;
    logic [31:0] m_mg, m_node, e_mg, e_node;
    int          e_idx;
    bit          e_fd;
    sum    = {1'b0, data} + {1'b0, m_mem[m_idx] >> FB};
    m_mg   = (sum > 33'h0_FFFF) ? 32'h0000_FFFF : sum[31:0];
    m_node = mg_stub(m_mg) ^ noise;
    e_mg = m_mg; e_node = m_node; e_idx = m_idx; e_fd = (m_idx == VN - 1);
    if (use_tab) begin
      e_mg = t_mg; e_node = t_node; e_idx = t_idx; e_fd = t_fd;
    end
    chk("in_ready_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    step();
    chk("mg_din", mg_din, e_mg);
    chk("in_ready_eval", 32'(in_ready), 32'd0);
    chk("busy_eval", 32'(busy), 32'd1);
    chk("node_valid_eval", 32'(node_valid), 32'd0);
    step();
    chk("node_valid", 32'(node_valid), 32'd1);
    chk("node_idx", 32'(node_idx), 32'(e_idx));
    chk("node_data", node_data, e_node);
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("busy_after", 32'(busy), 32'd0);
    m_mem[m_idx] = m_node;
    m_idx        = (m_idx == VN - 1) ? 0 : m_idx + 1;
    m_last_mg    = m_mg;
    m_last_node  = m_node;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mg_din"}, mg_din, 32'h0);
    chk({tag, "_node_valid"}, 32'(node_valid), 32'd0);
    chk({tag, "_node_idx"}, 32'(node_idx), 32'd0);
    chk({tag, "_node_data"}, node_data, 32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] mg;
    logic [31:0] node;
    int          idx;
    bit          fd;
  } vec_t;

  vec_t tab [22];

  initial begin
    // Frame 1: empty delay line. Frame 2: feedback 0x14>>1 = 0xA.
    for (int i = 0; i < 10; i++) tab[i] = '{32'h100, 32'h100, 32'h14, i, (i == 9)};
    for (int i = 0; i < 10; i++) tab[10+i] = '{32'h100, 32'h10A, 32'h14, i, (i == 9)};
    tab[20] = '{32'h0001_0000, 32'h0000_FFFF, 32'h4E, 0, 1'b0};
    tab[21] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h4E, 1, 1'b0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; noise = '0;
    model_reset();
    repeat (3) step();
    chk_all_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 22; i++)
      do_node(tab[i].din, 1'b1, tab[i].mg, tab[i].node, tab[i].idx, tab[i].fd);

    // Backpressure: producer goes idle for 5 cycles, outputs must hold.
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      chk("bp_node_valid", 32'(node_valid), 32'd0);
      chk("bp_busy", 32'(busy), 32'd0);
      chk("bp_mg_din", mg_din, 32'h0000_FFFF);
      chk("bp_node_data", node_data, 32'h4E);
      chk("bp_node_idx", 32'(node_idx), 32'd1);
    end

    // clear during EVAL of node 3: no pulse, no write, pointer back to 0.
    do_node(32'h200, 1'b0, 0, 0, 0, 1'b0);
    in_valid = 1'b1; in_data = 32'h300;
    step();
    chk("clr_busy_before", 32'(busy), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk_all_zero("clear");
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    // clear together with in_valid in ACCEPT drops the sample.
    in_valid = 1'b1; in_data = 32'h1234; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_drop_busy", 32'(busy), 32'd0);
    chk("clr_drop_mg_din", mg_din, 32'h0);
    chk("clr_drop_in_ready", 32'(in_ready), 32'd1);
    // Boundary: 0xFFFF with empty feedback passes unsaturated.
    do_node(32'h0000_FFFF, 1'b1, 32'h0000_FFFF, 32'h4E, 0, 1'b0);

    // Reset during EVAL of node 6.
    for (int i = 1; i < 6; i++) do_node($urandom_range(0, 32'h1_FFFF), 1'b0, 0, 0, 0, 1'b0);
    in_valid = 1'b1; in_data = 32'h777;
    step();
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    chk_all_zero("rst_mid");
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rel_node_valid", 32'(node_valid), 32'd0);
    model_reset();

    // Randomized traffic against the model, with idle gaps and noisy results.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 2))
        0:       d = $urandom_range(0, 32'hFFFF);
        1:       d = $urandom_range(32'hFF00, 32'h1_0100);
        default: d = $urandom;
      endcase
      noise = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      do_node(d, 1'b0, 0, 0, 0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          step();
          chk("gap_node_valid", 32'(node_valid), 32'd0);
          chk("gap_node_data", node_data, m_last_node);
          chk("gap_mg_din", mg_din, m_last_mg);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
